// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-128 decryption core: FSM states, round
// count, Rcon table, forward/inverse S-boxes and GF(2^8) helpers.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEYEXP  = 2'd1,
        ST_DECRYPT = 2'd2
    } dec_state_e;

    localparam int AES_NR = 10;

    // Entry 0 is unused so the table can be indexed directly by round number.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_x02(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_x09(input logic [7:0] b);
        return gf_x02(gf_x02(gf_x02(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_x0b(input logic [7:0] b);
        logic [7:0] b2;
        b2 = gf_x02(b);
        return gf_x02(gf_x02(b2)) ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] gf_x0d(input logic [7:0] b);
        logic [7:0] b4;
        b4 = gf_x02(gf_x02(b));
        return gf_x02(b4) ^ b4 ^ b;
    endfunction

    function automatic logic [7:0] gf_x0e(input logic [7:0] b);
        logic [7:0] b2;
        logic [7:0] b4;
        b2 = gf_x02(b);
        b4 = gf_x02(b2);
        return gf_x02(b4) ^ b4 ^ b2;
    endfunction

    // One step of the AES-128 key schedule: derive the next round key from
    // the previous one using RotWord, SubWord and the round constant.
    function automatic logic [127:0] expand_key(input logic [127:0] prev,
                                                input logic [7:0]   rcon);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and
// InvMixColumns, with InvMixColumns bypassed for the final round.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] blk,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] result
);

    logic [7:0] in_b  [16];
    logic [7:0] rk_b  [16];
    logic [7:0] ark_b [16];
    logic [7:0] mix_b [16];

    // Byte i sits at blk[127-8i -: 8]; bytes are column-major (row r, column c -> r+4c).
    always_comb begin
        result = '0;
        for (int i = 0; i < 16; i++) begin
            in_b[i] = blk[127 - 8*i -: 8];
            rk_b[i] = round_key[127 - 8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark_b[r + 4*c] = inv_sbox(in_b[r + 4*((c + 4 - r) % 4)]) ^ rk_b[r + 4*c];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_b[4*c]     = gf_x0e(ark_b[4*c]) ^ gf_x0b(ark_b[4*c+1]) ^
                             gf_x0d(ark_b[4*c+2]) ^ gf_x09(ark_b[4*c+3]);
            mix_b[4*c + 1] = gf_x09(ark_b[4*c]) ^ gf_x0e(ark_b[4*c+1]) ^
                             gf_x0b(ark_b[4*c+2]) ^ gf_x0d(ark_b[4*c+3]);
            mix_b[4*c + 2] = gf_x0d(ark_b[4*c]) ^ gf_x09(ark_b[4*c+1]) ^
                             gf_x0e(ark_b[4*c+2]) ^ gf_x0b(ark_b[4*c+3]);
            mix_b[4*c + 3] = gf_x0b(ark_b[4*c]) ^ gf_x0d(ark_b[4*c+1]) ^
                             gf_x09(ark_b[4*c+2]) ^ gf_x0e(ark_b[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            result[127 - 8*i -: 8] = last ? ark_b[i] : mix_b[i];
        end
    end

endmodule

// File: rtl/aes_dec_core.sv
// Iterative AES-128 inverse cipher: expands the key into an 11-entry
// round-key store, then decrypts one round per clock behind a load/busy
// handshake. Optional build macro AES_DEC_KEYREUSE_EN adds key_reuse_i and a
// key-cache-valid flag so a repeated key can skip the expansion phase.
module aes_dec_core
    import aes_dec_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [127:0] key_i,
    input  logic [127:0] data_i,
`ifdef AES_DEC_KEYREUSE_EN
    input  logic         key_reuse_i,
`endif
    output logic [127:0] data_o,
    output logic         busy_o,
    output logic         valid_o
);

    // Only NR=10 is meaningful; the counter is sized for it.
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    dec_state_e   fsm_q, fsm_d;
    logic [3:0]   round_q;
    logic [127:0] blk_q;
    logic [127:0] rk [0:10];
    logic [127:0] rk_cur, rk_prev, inv_out;
    logic [7:0]   rcon_cur;
    logic         accept;
    logic         reuse;

    assign accept = load_i && !busy_o;

`ifdef AES_DEC_KEYREUSE_EN
    logic key_cache_valid_q;

    assign reuse = key_reuse_i && key_cache_valid_q;

    // Cache is valid once a full expansion has finished; a fresh key load drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_cache_valid_q <= 1'b0;
        end else if (fsm_q == ST_IDLE && accept && !reuse) begin
            key_cache_valid_q <= 1'b0;
        end else if (fsm_q == ST_KEYEXP && round_q == LAST_ROUND) begin
            key_cache_valid_q <= 1'b1;
        end
    end
`else
    assign reuse = 1'b0;
`endif

    // Select the round key used this cycle and the predecessor feeding expansion.
    always_comb begin
        rk_cur   = '0;
        rk_prev  = '0;
        rcon_cur = 8'h00;
        if (round_q <= LAST_ROUND) begin
            rk_cur = rk[round_q];
        end
        if (round_q != 4'd0 && round_q <= LAST_ROUND) begin
            rk_prev  = rk[round_q - 4'd1];
            rcon_cur = RCON[round_q];
        end
    end

    aes_inv_round u_inv_round (
        .blk       (blk_q),
        .round_key (rk_cur),
        .last      (round_q == 4'd0),
        .result    (inv_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic: expand (unless the cached schedule is reused), then decrypt.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    fsm_d = reuse ? ST_DECRYPT : ST_KEYEXP;
                end
            end
            ST_KEYEXP: begin
                if (round_q == LAST_ROUND) begin
                    fsm_d = ST_DECRYPT;
                end
            end
            ST_DECRYPT: begin
                if (round_q == 4'd0) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Datapath: block state, round counter and registered host-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q   <= '0;
            round_q <= 4'd0;
            data_o  <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (accept) begin
                        blk_q   <= data_i;
                        data_o  <= '0;
                        busy_o  <= 1'b1;
                        round_q <= reuse ? LAST_ROUND : 4'd1;
                    end
                end
                ST_KEYEXP: begin
                    if (round_q != LAST_ROUND) begin
                        round_q <= round_q + 4'd1;
                    end
                end
                ST_DECRYPT: begin
                    if (round_q == LAST_ROUND) begin
                        blk_q   <= blk_q ^ rk_cur;
                        round_q <= LAST_ROUND - 4'd1;
                    end else if (round_q == 4'd0) begin
                        data_o  <= inv_out;
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        blk_q   <= inv_out;
                        round_q <= round_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key store; deliberately not reset so a cached schedule survives idle time.
    always_ff @(posedge clk) begin
        if (fsm_q == ST_IDLE && accept && !reuse) begin
            rk[0] <= key_i;
        end else if (fsm_q == ST_KEYEXP && round_q != 4'd0 && round_q <= LAST_ROUND) begin
            rk[round_q] <= expand_key(rk_prev, rcon_cur);
        end
    end

endmodule

// File: doc/aes_dec_core.md
# aes_dec_core

Iterative AES-128 inverse cipher (FIPS-197 §5.3) that recovers plaintext from ciphertext produced by the team's forward AES encryption core. It expands the 128-bit cipher key on-chip into an 11-entry round-key store, then runs InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns one round per clock. It sits beside the encryption core behind the same load/busy command interface, so a host driver can target either engine without change.

## Interface
Parameters:
- NR, 10, number of cipher rounds; only 10 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous and active-low.
- load_i  input  1  start request; sampled only while busy_o=0.
- key_i  input  128  cipher key; byte 0 is key_i[127:120].
- data_i  input  128  ciphertext block, same byte order.
- key_reuse_i  input  1  skip key expansion (present only with AES_DEC_KEYREUSE_EN).
- data_o  output  128  plaintext; holds its value until the next accepted load.
- busy_o  output  1  core occupied.
- valid_o  output  1  one-cycle pulse; data_o is new.

## Operation
- FSM states are IDLE, KEYEXP and DECRYPT; `rk[0..10]` is a 128-bit round-key register array.
- Accepted load (edge E0, load_i=1 and busy_o=0):
  - rk[0] <= key_i; state <= data_i; round <= 1; data_o <= 0; busy_o <= 1.
  - Next state is KEYEXP.
- KEYEXP:
  - Each edge: rk[round] <= ExpandKey(rk[round-1], Rcon[round]), with Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - Completes at round 10, then moves to DECRYPT with round <= 10.
- DECRYPT:
  - First edge: state <= state ^ rk[10]; round <= 9.
  - Rounds 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[round]); round decrements.
  - Final edge (round 0): result = InvSubBytes(InvShiftRows(state)) ^ rk[0]; data_o <= result; valid_o <= 1; busy_o <= 0; return to IDLE.
- load_i while busy_o=1 is ignored; there is no queueing and no error flag.
- key_i and data_i are sampled only at E0 and may change afterwards.
- The round-key store keeps its contents after a block completes.

## Timing
- Reset values: data_o=0, busy_o=0, valid_o=0, FSM=IDLE, round=0, key-cache-valid=0. The round-key store is not reset.
- Assertion of rst_n low mid-operation aborts immediately:
  - No valid_o pulse is produced.
  - data_o returns to 0.
  - The key cache is invalidated.
- Full-expansion latency: result and valid_o are registered at E21, so valid_o is high for the cycle after E21.
- busy_o is high from E0+ through E21-.
- The earliest next load is sampled at E21+1. At E21 itself the registered busy_o is still 1, so a load presented there is ignored.
- Back-to-back throughput is one block per 22 cycles.

## Configuration
- `AES_DEC_KEYREUSE_EN` defined:
  - Adds the key_reuse_i port and a key-cache-valid flag, set when a KEYEXP completes.
  - A load with key_reuse_i=1 and cache valid skips KEYEXP: it goes straight to DECRYPT, keeps rk[1..10], ignores key_i, and delivers the result at E11.
  - key_reuse_i=1 with cache invalid performs a normal full expansion.
- Not defined: no port and no flag; every load expands the key (22-cycle latency).

## Structure
- Package `aes_dec_pkg` holds:
  - FSM state enum.
  - NR and the Rcon table.
  - Forward and inverse S-box byte tables.
  - GF(2^8) multiply functions: x02, x09, x0b, x0d, x0e.
- Sub-module `aes_inv_round` is a combinational block:
  - Inputs: state, round key, last flag.
  - Output: next state, with InvMixColumns bypassed when last=1.
- Key expansion SubWord uses four forward S-box lookups from the package.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_i 69c4e0d86a7b0430d8cdb78070b4c55a -> data_o 00112233445566778899aabbccddeeff, valid_o exactly 21 edges after load.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, data_i 3925841d02dc09fbdc118597196a0b32 -> data_o 3243f6a8885a308d313198a2e0370734.
- Load pulsed at every cycle while busy -> single result, unchanged vs C.1, busy_o never retriggered early; load at E21 ignored, load at E22 accepted.
- rst_n low at E8 of a C.1 run -> busy_o, valid_o, data_o all 0 asynchronously; no valid_o; subsequent C.1 run correct.
- With AES_DEC_KEYREUSE_EN: run C.1, then key_reuse_i=1 with key_i=0 and C.1 ciphertext -> correct plaintext, valid_o 11 edges after load; after reset, same request -> 21-edge latency.
- Random key/plaintext pairs encrypted by the encryption core, fed back -> original plaintext recovered, 1000 iterations.
